dp_ram_ctrl: RTL and testbench
==============================

Name: dp_ram_ctrl

Overview:
Parametrised simple-dual-port synchronous RAM with controller logic. It is the successor to the dot-product operand memories.
- Adds per-byte write enables, selectable read latency (1 or 2) and defined read-during-write behaviour.
- Adds an output valid strobe, out-of-range address detection, and a hardware clear sequencer that zeroes the array on request.
- Sits between the operand loaders (write side) and the dot-product datapath / mem readers (read side).

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- MEM_SIZE, 64: number of words; need not be a power of two.
- ADDR_WIDTH, 6: address width; must satisfy 2**ADDR_WIDTH >= MEM_SIZE.
- RD_LATENCY, 1: read_en to data_valid latency in cycles; legal values 1 or 2.
- RDW_MODE, 0: same-address read/write in one cycle. 0 = old data; 1 = new data, with byte-merge.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  single-cycle request to zero the whole array
- clear_busy  out  1  high while the clear sequence runs
- clear_done  out  1  one-cycle pulse when the clear completes
- write_en  in  1  write strobe
- write_address  in  ADDR_WIDTH  write word address
- byte_en  in  DATA_WIDTH/8  per-byte lane write enable
- data_in  in  DATA_WIDTH  write data
- read_en  in  1  read strobe
- read_address  in  ADDR_WIDTH  read word address
- data_out  out  DATA_WIDTH  registered read data
- data_valid  out  1  data_out holds the result of a read
- addr_err  out  1  sticky flag: an out-of-range address (>= MEM_SIZE) was presented

Behaviour:
- Reset (async, rst=1): data_out=0, data_valid=0, clear_busy=0, clear_done=0, addr_err=0, FSM=IDLE, clear counter=0. Array contents are not reset.
- Write: on a clk edge with write_en=1, not busy and write_address < MEM_SIZE, only lanes with byte_en[i]=1 are updated. byte_en=0 means no write.
- Read: read_en sampled at edge N → data_out/data_valid updated at edge N+RD_LATENCY.
  - data_valid is high for exactly one cycle per accepted read; back-to-back reads give a continuous valid stream.
  - When no read is in flight, data_out holds its last value and data_valid=0.
- RD_LATENCY=2 adds one output register stage; valid is pipelined alongside the data.
- Read-during-write, same address, same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the old word with enabled lanes replaced by data_in.
  - Different addresses: no interaction.
- Out-of-range address (>= MEM_SIZE):
  - Write is dropped.
  - Read still produces data_valid on schedule, with data_out=0.
  - addr_err is set on the edge the access is sampled and held until rst.
- Clear FSM:
  - IDLE: clear_req=1 → CLEAR; counter=0; clear_busy=1 from the next cycle.
  - CLEAR: writes 0 to mem[counter] each cycle and increments the counter. After address MEM_SIZE-1 is written → DONE. Takes MEM_SIZE cycles.
  - DONE: clear_done=1 for one cycle, clear_busy=0 → IDLE.
  - clear_req while in CLEAR/DONE is ignored (no queuing).
- While clear_busy=1:
  - write_en and read_en are ignored: no write, no valid, no addr_err update.
  - Reads already in the latency pipeline complete normally.
- Simultaneous clear_req and write/read in IDLE: the user access on that edge completes; the clear starts on the same edge.
- rst during CLEAR: FSM returns to IDLE at once and no clear_done is issued. Array is left partially cleared; bench must not check the uncleared region.

Decomposition:
- Shared package dp_mem_pkg:
  - localparam NUM_BYTES = DATA_WIDTH/8
  - clear FSM state enum {IDLE, CLEAR, DONE}
  - RDW_OLD/RDW_NEW constants
  - elaboration checks on the parameter rules above
- One natural sub-module: dp_ram_core, the bare byte-enabled array with a registered read and RDW_MODE handling.
- dp_ram_ctrl wraps dp_ram_core and adds the clear FSM, range checks, latency pipeline and addr_err.

Test Plan:
1. Write 0xA1B2C3D4 to addr 5 with byte_en=4'hF, then read addr 5 → data_valid at edge N+1 (RD_LATENCY=1), data_out=0xA1B2C3D4.
2. Partial write 0x11223344 to addr 5 with byte_en=4'b0101, then read → 0xA122C344.
3. Same-edge write 0xFFFFFFFF (byte_en=4'b0011) and read at addr 7 holding 0x12345678. RDW_MODE=0 → 0x12345678; RDW_MODE=1 → 0x1234FFFF.
4. clear_req with MEM_SIZE=64:
   - clear_busy high for 64 cycles, then clear_done pulses once.
   - A read_en issued mid-clear gives no valid.
   - Reads of addrs 0, 31, 63 afterwards → 0.
5. RD_LATENCY=2, back-to-back reads of addrs 0..3 → data_valid high for 4 consecutive cycles, starting two edges after the first read_en, with data in order.
6. MEM_SIZE=48, ADDR_WIDTH=6:
   - Write to addr 50 is dropped.
   - Read of addr 50 → valid with 0; addr_err=1 stays high until rst.
   - rst asserted at clear cycle 10 → FSM idle, clear_busy=0, no clear_done.

Source files
------------

// File: rtl/dp_mem_pkg.sv
// Shared types, constants and parameter checks for the dot-product
// operand RAM and its controller.
package dp_mem_pkg;

  // Clear sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Read-during-write selection for a same-address, same-edge access
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Byte-lane count of the default 32-bit word
  localparam int DEF_DATA_WIDTH = 32;
  localparam int NUM_BYTES      = DEF_DATA_WIDTH / 8;

  // Number of byte lanes in a word of the given width
  function automatic int num_bytes(input int data_width);
    return data_width / 8;
  endfunction

  // True when a parameter set describes a buildable memory
  function automatic bit params_ok(input int dw, input int ms, input int aw,
                                   input int lat, input int rdw);
    bit ok;
    ok = (dw > 0) && ((dw % 8) == 0);
    ok = ok && (ms > 0) && (aw > 0) && (aw < 31);
    ok = ok && ((64'd1 << aw) >= 64'(ms));
    ok = ok && ((lat == 1) || (lat == 2));
    ok = ok && ((rdw == RDW_OLD) || (rdw == RDW_NEW));
    return ok;
  endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Bare byte-enabled simple-dual-port array with one registered read stage.
// Same-address read-during-write returns either the stored word or the
// stored word with the written lanes merged in, depending on RDW_MODE.
module dp_ram_core
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int BYTES = num_bytes(DATA_WIDTH);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] SIZE_W = AW1'(MEM_SIZE);

  logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rd_next_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  rdw_hit_s;

  // Guard the array index on both ports so no access falls off the end
  assign wr_in_range_s = ({1'b0, wr_addr} < SIZE_W);
  assign rd_in_range_s = ({1'b0, rd_addr} < SIZE_W);
  assign rdw_hit_s     = (RDW_MODE == RDW_NEW) && wr_en && wr_in_range_s &&
                         (wr_addr == rd_addr);

  // Byte-lane writes into the array; the storage itself carries no reset
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_s) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) begin
          mem_r[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Select the read word: zero when out of range, lane-merged on a new-data hit
  always_comb begin
    rd_word_s = '0;
    rd_next_s = '0;
    if (rd_in_range_s) begin
      rd_word_s = mem_r[rd_addr];
    end else begin
      rd_word_s = '0;
    end
    for (int i = 0; i < BYTES; i++) begin
      if (rdw_hit_s && wr_be[i]) begin
        rd_next_s[8*i +: 8] = wr_data[8*i +: 8];
      end else begin
        rd_next_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end

  // Registered read port: data updates only on a read, valid pulses per read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_next_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/dp_ram_ctrl.sv
// Operand RAM controller: wraps dp_ram_core with address range checking,
// a sticky address-error flag, an optional second read stage and a clear
// sequencer that zeroes the whole array one word per cycle.
module dp_ram_ctrl
  import dp_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic                    clear_done,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    addr_err
);

  localparam int BYTES = num_bytes(DATA_WIDTH);
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0]        SIZE_W    = AW1'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  if (!params_ok(DATA_WIDTH, MEM_SIZE, ADDR_WIDTH, RD_LATENCY, RDW_MODE)) begin : g_param_check
    $error("dp_ram_ctrl: illegal parameter combination");
  end

  clr_state_e            state_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic                  clear_busy_r;
  logic                  clear_done_r;
  logic                  addr_err_r;

  logic                  busy_s;
  logic                  wr_oor_s;
  logic                  rd_oor_s;
  logic                  user_wr_s;
  logic                  user_rd_s;

  logic                  core_we_s;
  logic [ADDR_WIDTH-1:0] core_waddr_s;
  logic [BYTES-1:0]      core_be_s;
  logic [DATA_WIDTH-1:0] core_wdata_s;
  logic [DATA_WIDTH-1:0] core_rdata_s;
  logic                  core_rvalid_s;

  // User traffic is locked out only while words are actually being cleared
  assign busy_s    = (state_r == CLEAR);
  assign wr_oor_s  = ({1'b0, write_address} >= SIZE_W);
  assign rd_oor_s  = ({1'b0, read_address} >= SIZE_W);
  assign user_wr_s = write_en && !busy_s && !wr_oor_s;
  assign user_rd_s = read_en && !busy_s;

  // Write-port mux: the clear sequencer owns the write port while busy
  always_comb begin
    core_we_s    = 1'b0;
    core_waddr_s = '0;
    core_be_s    = '0;
    core_wdata_s = '0;
    if (busy_s) begin
      core_we_s    = 1'b1;
      core_waddr_s = clr_cnt_r;
      core_be_s    = '1;
      core_wdata_s = '0;
    end else begin
      core_we_s    = user_wr_s;
      core_waddr_s = write_address;
      core_be_s    = byte_en;
      core_wdata_s = data_in;
    end
  end

  dp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_SIZE   (MEM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RDW_MODE   (RDW_MODE)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (core_we_s),
    .wr_addr  (core_waddr_s),
    .wr_be    (core_be_s),
    .wr_data  (core_wdata_s),
    .rd_en    (user_rd_s),
    .rd_addr  (read_address),
    .rd_data  (core_rdata_s),
    .rd_valid (core_rvalid_s)
  );

  // Clear sequencer: walk every address once, then pulse done for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      clr_cnt_r    <= '0;
      clear_busy_r <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          clear_done_r <= 1'b0;
          if (clear_req) begin
            state_r      <= CLEAR;
            clr_cnt_r    <= '0;
            clear_busy_r <= 1'b1;
          end else begin
            state_r      <= IDLE;
            clear_busy_r <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r      <= DONE;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            clr_cnt_r    <= clr_cnt_r + ADDR_WIDTH'(1);
            clear_busy_r <= 1'b1;
            clear_done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r      <= IDLE;
          clear_busy_r <= 1'b0;
          clear_done_r <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          clr_cnt_r    <= '0;
          clear_busy_r <= 1'b0;
          clear_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky out-of-range flag, updated only for accesses that are not locked out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_r <= 1'b0;
    end else if (!busy_s && ((write_en && wr_oor_s) || (read_en && rd_oor_s))) begin
      addr_err_r <= 1'b1;
    end else begin
      addr_err_r <= addr_err_r;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] data_q_r;
    logic                  valid_q_r;

    // Extra output stage: valid travels with the data, data holds between reads
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q_r  <= '0;
        valid_q_r <= 1'b0;
      end else begin
        valid_q_r <= core_rvalid_s;
        if (core_rvalid_s) begin
          data_q_r <= core_rdata_s;
        end else begin
          data_q_r <= data_q_r;
        end
      end
    end

    assign data_out   = data_q_r;
    assign data_valid = valid_q_r;
  end else begin : g_lat1
    assign data_out   = core_rdata_s;
    assign data_valid = core_rvalid_s;
  end

  assign clear_busy = clear_busy_r;
  assign clear_done = clear_done_r;
  assign addr_err   = addr_err_r;

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Scoreboard bench for dp_ram_ctrl. Two instances share the stimulus:
//   dut_a: 64 words, read latency 1, old-data read-during-write
//   dut_b: 48 words, read latency 2, new-data read-during-write
module tb_dp_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        write_en;
  logic [5:0]  write_address;
  logic [3:0]  byte_en;
  logic [31:0] data_in;
  logic        read_en;
  logic [5:0]  read_address;

  logic        a_busy, a_done, a_valid, a_err;
  logic [31:0] a_dout;
  logic        b_busy, b_done, b_valid, b_err;
  logic [31:0] b_dout;

  dp_ram_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(64), .ADDR_WIDTH(6),
                .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(a_busy),
    .clear_done(a_done), .write_en(write_en), .write_address(write_address),
    .byte_en(byte_en), .data_in(data_in), .read_en(read_en),
    .read_address(read_address), .data_out(a_dout), .data_valid(a_valid),
    .addr_err(a_err));

  dp_ram_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(48), .ADDR_WIDTH(6),
                .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(b_busy),
    .clear_done(b_done), .write_en(write_en), .write_address(write_address),
    .byte_en(byte_en), .data_in(data_in), .read_en(read_en),
    .read_address(read_address), .data_out(b_dout), .data_valid(b_valid),
    .addr_err(b_err));

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expectation, on its due cycle
  always @(negedge clk) begin
    if (!rst && a_valid) begin
      if (qa.size() == 0) begin
        check("a_spurious_valid", {31'd0, a_valid}, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_read_data", a_dout, ea.data);
        check("a_read_cycle", cyc, ea.due);
      end
    end
    if (!rst && b_valid) begin
      if (qb.size() == 0) begin
        check("b_spurious_valid", {31'd0, b_valid}, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_read_data", b_dout, eb.data);
        check("b_read_cycle", cyc, eb.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] xa, input logic [31:0] xb);
    qa.push_back('{data: xa, due: cyc + 1});
    qb.push_back('{data: xb, due: cyc + 2});
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    write_en = 1'b1; write_address = a; data_in = d; byte_en = be;
    tick();
    write_en = 1'b0; byte_en = 4'h0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] xa, input logic [31:0] xb);
    read_en = 1'b1; read_address = a;
    push(xa, xb);
    tick();
    read_en = 1'b0;
  endtask

  task automatic wr_rd(input logic [5:0] wa, input logic [31:0] d, input logic [3:0] be,
                       input logic [5:0] ra, input logic [31:0] xa, input logic [31:0] xb);
    write_en = 1'b1; write_address = wa; data_in = d; byte_en = be;
    read_en = 1'b1; read_address = ra;
    push(xa, xb);
    tick();
    write_en = 1'b0; byte_en = 4'h0; read_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy_a_n, busy_b_n, done_a_n, done_b_n, done_a_at, done_b_at;
    rst = 1'b1; clear_req = 1'b0; write_en = 1'b0; write_address = 6'd0;
    byte_en = 4'h0; data_in = 32'd0; read_en = 1'b0; read_address = 6'd0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    check("rst_a_dout", a_dout, 32'd0);
    check("rst_b_dout", b_dout, 32'd0);
    check("rst_flags_a", {28'd0, a_valid, a_busy, a_done, a_err}, 32'd0);
    check("rst_flags_b", {28'd0, b_valid, b_busy, b_done, b_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Full-word write then read
    wr(6'd5, 32'hA1B2C3D4, 4'hF);
    rd(6'd5, 32'hA1B2C3D4, 32'hA1B2C3D4);
    // Partial write: lanes 0 and 2
    wr(6'd5, 32'h11223344, 4'b0101);
    rd(6'd5, 32'hA122C344, 32'hA122C344);

    // Same-address read-during-write
    wr(6'd7, 32'h12345678, 4'hF);
    wr_rd(6'd7, 32'hFFFFFFFF, 4'b0011, 6'd7, 32'h12345678, 32'h1234FFFF);
    rd(6'd7, 32'h1234FFFF, 32'h1234FFFF);
    // Different addresses on the same edge do not interact
    wr(6'd8, 32'hCAFEF00D, 4'hF);
    wr_rd(6'd9, 32'h00000000, 4'hF, 6'd8, 32'hCAFEF00D, 32'hCAFEF00D);
    tick(); tick();
    // Outputs hold the last read with valid low
    check("hold_a_dout", a_dout, 32'hCAFEF00D);
    check("hold_b_dout", b_dout, 32'hCAFEF00D);
    check("hold_valid", {30'd0, a_valid, b_valid}, 32'd0);

    // Back-to-back reads: continuous valid stream, data in order
    for (int i = 0; i < 4; i++) wr(6'(i), 32'hA0 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) begin
      read_en = 1'b1; read_address = 6'(i);
      push(32'hA0 + 32'(i), 32'hA0 + 32'(i));
      tick();
    end
    read_en = 1'b0;
    tick(); tick();

    // Address 50: in range for dut_a, out of range for dut_b
    check("err_before", {30'd0, a_err, b_err}, 32'd0);
    wr(6'd50, 32'hDEADBEEF, 4'hF);
    check("err_after_write", {30'd0, a_err, b_err}, 32'd1);
    rd(6'd50, 32'hDEADBEEF, 32'd0);
    rd(6'd2, 32'hA2, 32'hA2);
    tick(); tick();

    // Clear starts on the same edge as a user read, which still completes
    clear_req = 1'b1; read_en = 1'b1; read_address = 6'd5;
    push(32'hA122C344, 32'hA122C344);
    tick();
    clear_req = 1'b0; read_en = 1'b0;
    busy_a_n = 0; busy_b_n = 0; done_a_n = 0; done_b_n = 0;
    done_a_at = -1; done_b_at = -1;
    for (int k = 0; k < 70; k++) begin
      if (a_busy) busy_a_n++;
      if (b_busy) busy_b_n++;
      if (a_done) begin done_a_n++; done_a_at = k; end
      if (b_done) begin done_b_n++; done_b_at = k; end
      read_en = (k == 20);
      read_address = 6'd5;
      clear_req = (k == 30);
      tick();
    end
    read_en = 1'b0; clear_req = 1'b0;
    check("clr_busy_cycles_a", busy_a_n, 32'd64);
    check("clr_busy_cycles_b", busy_b_n, 32'd48);
    check("clr_done_count_a", done_a_n, 32'd1);
    check("clr_done_count_b", done_b_n, 32'd1);
    check("clr_done_when_a", done_a_at, 32'd64);
    check("clr_done_when_b", done_b_at, 32'd48);
    rd(6'd0, 32'd0, 32'd0);
    rd(6'd31, 32'd0, 32'd0);
    rd(6'd63, 32'd0, 32'd0);
    rd(6'd5, 32'd0, 32'd0);
    tick(); tick();
    check("err_held", {30'd0, a_err, b_err}, 32'd1);

    // Reset in the middle of a clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    check("clr_running", {30'd0, a_busy, b_busy}, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_clear_flags", {26'd0, a_busy, b_busy, a_done, b_done, a_err, b_err}, 32'd0);
    check("rst_mid_clear_dout", a_dout | b_dout, 32'd0);
    tick(); tick();
    rst = 1'b0;
    busy_a_n = 0; done_a_n = 0;
    for (int k = 0; k < 70; k++) begin
      if (a_busy || b_busy) busy_a_n++;
      if (a_done || b_done) done_a_n++;
      tick();
    end
    check("post_rst_busy", busy_a_n, 32'd0);
    check("post_rst_done", done_a_n, 32'd0);
    wr(6'd3, 32'h0BADF00D, 4'hF);
    rd(6'd3, 32'h0BADF00D, 32'h0BADF00D);
    repeat (4) tick();
    check("a_pending", qa.size(), 32'd0);
    check("b_pending", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
